mul_shift_add: RTL and testbench
================================

MUL_SHIFT_ADD -- requirements
Module: mul_shift_add

Interface
REQ-001 SHALL have parameter XLEN, default 64, operand and result width; only 32 and 64 are legal.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  block can accept a request.
REQ-006 SHALL have port op  input  2  00 MUL (low XLEN), 01 MULH (s x s, high), 10 MULHSU (s x u, high), 11 MULHU (u x u, high).
REQ-007 SHALL have port rs1  input  XLEN  multiplicand.
REQ-008 SHALL have port rs2  input  XLEN  multiplier.
REQ-009 SHALL have port kill  input  1  synchronous abort of any in-flight or pending result.
REQ-010 SHALL have port out_valid  output  1  result valid.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  XLEN  selected product half.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> NEG_LO -> NEG_HI -> DONE -> IDLE.
REQ-014 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid && in_ready && !kill.
REQ-015 On accept, SHALL latch op, |rs1| and |rs2| (two's-complement magnitude for operands treated as signed per op, raw otherwise), neg_flag = sign(rs1_signed) XOR sign(rs2_signed), and clear the 2*XLEN product register and a counter.
REQ-016 Magnitude of the most negative value (e.g. 0x8000_0000_0000_0000) SHALL be 2^(XLEN-1), held as unsigned XLEN bits without overflow.
REQ-017 CALC SHALL run exactly XLEN cycles: per cycle, if multiplier LSB = 1, add multiplicand to the product's upper XLEN bits; shift {carry, sum, lower half} right by 1; shift the multiplier right by 1.
REQ-018 The per-cycle add SHALL use one CLA instance (WIDTH = XLEN, Ci = 0), and its Co SHALL be the bit shifted into the product MSB.
REQ-019 NEG_LO SHALL, if neg_flag, replace the lower half with ~lo + 1 through the same CLA instance and register the carry-out; otherwise hold it.
REQ-020 NEG_HI SHALL, if neg_flag, replace the upper half with ~hi + registered carry; otherwise hold it.
REQ-021 Both NEG states SHALL always be traversed, giving a fixed latency of XLEN + 3 cycles from the accept edge to out_valid = 1 (67 for XLEN = 64).
REQ-022 In DONE, out_valid SHALL be 1 and result SHALL be the lower half for op 00 and the upper half otherwise, held stable until out_valid && out_ready.
REQ-023 After handshake completion the FSM SHALL return to IDLE; in_ready rises the following cycle, so there is no same-cycle accept-on-retire.
REQ-024 kill SHALL force IDLE on the next edge from any state, has priority over in_valid and out_ready, and discards the pending result.
REQ-025 out_valid SHALL be 0 in every state other than DONE; result SHALL be 0 outside DONE.
REQ-026 Zero operands SHALL NOT shorten latency.

Reset
REQ-027 With rst_n = 0 at a clock edge: state = IDLE, in_ready = 1, out_valid = 0, result = 0, and the product, counter and neg_flag registers are cleared.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abandon the operation with no result emitted.
REQ-029 in_ready SHALL be 1 during reset and in the first cycle after reset release, but no request SHALL be accepted while rst_n = 0.

Verification
REQ-030 Case 1: MUL 7 x 6 (XLEN = 64) -> out_valid exactly 67 cycles after accept, result = 42.
REQ-031 Case 2: MULH 0x8000_0000_0000_0000 x 0x8000_0000_0000_0000 -> result = 0x4000_0000_0000_0000; the MUL variant gives 0.
REQ-032 Case 3: MULHSU -1 x 0xFFFF_FFFF_FFFF_FFFF -> result = 0xFFFF_FFFF_FFFF_FFFF; MULHU on the same operands gives 0xFFFF_FFFF_FFFF_FFFE.
REQ-033 Case 4: kill at CALC cycle 30 -> IDLE next cycle, no out_valid pulse; a following MUL 3 x 5 gives 15.
REQ-034 Case 5: out_ready held low 10 cycles in DONE -> result and out_valid stable throughout; in_valid during DONE is not accepted.
REQ-035 Case 6: rst_n low for 1 cycle mid-CALC -> reset values per REQ-027; 10k-vector random run vs reference model for all ops at XLEN 32 and 64.

Source files
------------

// File: rtl/mul_shift_add.sv
// Sequential shift-and-add multiplier producing MUL/MULH/MULHSU/MULHU results.
// Signed operands are multiplied as magnitudes, and the 2*XLEN product is negated afterwards.

module cla #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic [WIDTH-1:0] sum,
    output logic             co
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [WIDTH:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Four-bit lookahead groups; only the group carry ripples between groups.
    always_comb begin
        c = '0;
        c[0] = ci;
        for (int k = 0; k < WIDTH / 4; k++) begin
            c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
            c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+3] & p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
        end
    end

    assign sum = p ^ c[WIDTH-1:0];
    assign co  = c[WIDTH];

endmodule

module mul_shift_add #(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);

    typedef enum logic [2:0] {
        IDLE,
        CALC,
        NEG_LO,
        NEG_HI,
        DONE
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic [2*XLEN-1:0] prod;
    logic [CNT_W-1:0]  cnt;
    logic              neg_flag;
    logic              neg_carry;
    logic [1:0]        op_q;

    logic              rs1_neg;
    logic              rs2_neg;
    logic [XLEN-1:0]   rs1_mag;
    logic [XLEN-1:0]   rs2_mag;
    logic              accept;

    logic [XLEN-1:0]   cla_a;
    logic [XLEN-1:0]   cla_b;
    logic [XLEN-1:0]   cla_sum;
    logic              cla_co;

    // The magnitude of the most negative value wraps to 2^(XLEN-1), which is exact when read as unsigned.
    assign rs1_neg = ((op == 2'b01) || (op == 2'b10)) && rs1[XLEN-1];
    assign rs2_neg = (op == 2'b01) && rs2[XLEN-1];
    assign rs1_mag = rs1_neg ? (~rs1 + XLEN'(1)) : rs1;
    assign rs2_mag = rs2_neg ? (~rs2 + XLEN'(1)) : rs2;
    assign accept  = in_valid && in_ready && !kill;

    cla #(
        .WIDTH (XLEN)
    ) u_cla (
        .a   (cla_a),
        .b   (cla_b),
        .ci  (1'b0),
        .sum (cla_sum),
        .co  (cla_co)
    );

    always_comb begin
        cla_a = prod[2*XLEN-1:XLEN];
        cla_b = mplier[0] ? mcand : '0;
        case (state)
            NEG_LO: begin
                cla_a = ~prod[XLEN-1:0];
                cla_b = XLEN'(1);
            end
            NEG_HI: begin
                cla_a = ~prod[2*XLEN-1:XLEN];
                cla_b = {{(XLEN-1){1'b0}}, neg_carry};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CALC;
            CALC:    if (cnt == CNT_W'(XLEN - 1)) state_next = NEG_LO;
            NEG_LO:  state_next = NEG_HI;
            NEG_HI:  state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (kill) begin
            state_next = IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mcand     <= '0;
            mplier    <= '0;
            prod      <= '0;
            cnt       <= '0;
            neg_flag  <= 1'b0;
            neg_carry <= 1'b0;
            op_q      <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q      <= op;
                        mcand     <= rs1_mag;
                        mplier    <= rs2_mag;
                        neg_flag  <= rs1_neg ^ rs2_neg;
                        neg_carry <= 1'b0;
                        prod      <= '0;
                        cnt       <= '0;
                    end
                end
                CALC: begin
                    prod   <= {cla_co, cla_sum, prod[XLEN-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                NEG_LO: begin
                    if (neg_flag) begin
                        prod[XLEN-1:0] <= cla_sum;
                        neg_carry      <= cla_co;
                    end
                end
                NEG_HI: begin
                    if (neg_flag) begin
                        prod[2*XLEN-1:XLEN] <= cla_sum;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign result    = (state != DONE)  ? '0 :
                       (op_q == 2'b00)  ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

endmodule

// File: tb/tb_mul_shift_add.sv
// Self-checking bench for mul_shift_add (XLEN = 64): directed cases, kill/reset aborts,
// backpressure and randomized operations compared against a 128-bit arithmetic reference.

module tb_mul_shift_add;

    localparam int XLEN    = 64;
    localparam int LATENCY = XLEN + 3;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      op = 2'b00;
    logic [XLEN-1:0] rs1 = '0;
    logic [XLEN-1:0] rs2 = '0;
    logic            kill = 1'b0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mul_shift_add #(
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .rs1       (rs1),
        .rs2       (rs2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    // Full-width signed/unsigned product, then pick the requested half.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] p;
        ea = (o == 2'b01 || o == 2'b10) ? {{64{a[63]}}, a} : {64'b0, a};
        eb = (o == 2'b01) ? {{64{b[63]}}, b} : {64'b0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[63:0] : p[127:64];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Latency is counted in edges with the accept edge as the first.
    task automatic do_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         input int stall, input bit junk, output logic [63:0] res,
                         output int lat, output bit stable, output bit post_ok);
        res     = '0;
        lat     = -1;
        stable  = 1'b1;
        post_ok = 1'b0;
        for (int i = 0; i < 10 && !in_ready; i++) tick();
        in_valid = 1'b1;
        op       = o;
        rs1      = a;
        rs2      = b;
        tick();
        in_valid = 1'b0;
        op       = 2'($urandom);
        rs1      = {$urandom, $urandom};
        rs2      = {$urandom, $urandom};
        for (int c = 1; c < 200; c++) begin
            if (out_valid === 1'b1) begin
                lat = c;
                break;
            end
            tick();
        end
        if (lat < 0) return;
        res = result;
        for (int s = 0; s < stall; s++) begin
            in_valid = junk;
            rs1      = {$urandom, $urandom};
            tick();
            if (out_valid !== 1'b1 || result !== res || in_ready !== 1'b0) stable = 1'b0;
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        post_ok   = (out_valid === 1'b0 && in_ready === 1'b1 && result === '0);
        in_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        op       = 2'b00;
        rs1      = 64'd7;
        rs2      = 64'd6;
        tick();
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (result !== '0) begin errors++; $display("[TB] FAIL reset_result got=%h exp=0", result); end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL release_in_ready got=%b exp=1", in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL no_accept_in_reset got=%b exp=1", in_ready); end
    endtask

    task automatic test_directed();
        logic [1:0]  t_op  [6];
        logic [63:0] t_a   [6];
        logic [63:0] t_b   [6];
        logic [63:0] t_exp [6];
        logic [63:0] res;
        int          lat;
        bit          stable;
        bit          post_ok;
        t_op[0] = 2'b00; t_a[0] = 64'd7;                 t_b[0] = 64'd6;                 t_exp[0] = 64'd42;
        t_op[1] = 2'b01; t_a[1] = 64'h8000_0000_0000_0000; t_b[1] = 64'h8000_0000_0000_0000; t_exp[1] = 64'h4000_0000_0000_0000;
        t_op[2] = 2'b00; t_a[2] = 64'h8000_0000_0000_0000; t_b[2] = 64'h8000_0000_0000_0000; t_exp[2] = 64'h0;
        t_op[3] = 2'b10; t_a[3] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[3] = 64'hFFFF_FFFF_FFFF_FFFF; t_exp[3] = 64'hFFFF_FFFF_FFFF_FFFF;
        t_op[4] = 2'b11; t_a[4] = 64'hFFFF_FFFF_FFFF_FFFF; t_b[4] = 64'hFFFF_FFFF_FFFF_FFFF; t_exp[4] = 64'hFFFF_FFFF_FFFF_FFFE;
        t_op[5] = 2'b00; t_a[5] = 64'h0;                  t_b[5] = 64'h0;                  t_exp[5] = 64'h0;
        for (int i = 0; i < 6; i++) begin
            do_op(t_op[i], t_a[i], t_b[i], 0, 1'b0, res, lat, stable, post_ok);
            checks++;
            if (lat !== LATENCY) begin errors++; $display("[TB] FAIL directed_latency #%0d got=%0d exp=%0d", i, lat, LATENCY); end
            checks++;
            if (res !== t_exp[i]) begin errors++; $display("[TB] FAIL directed_result #%0d got=%h exp=%h", i, res, t_exp[i]); end
            checks++;
            if (!post_ok) begin errors++; $display("[TB] FAIL directed_retire #%0d got out_valid=%b in_ready=%b exp 0/1", i, out_valid, in_ready); end
        end
    endtask

    task automatic test_kill();
        logic [63:0] res;
        int          lat;
        bit          stable;
        bit          post_ok;
        bit          seen;
        in_valid = 1'b1;
        op       = 2'b00;
        rs1      = 64'd9;
        rs2      = 64'd9;
        tick();
        in_valid = 1'b0;
        repeat (30) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL kill_calc got in_ready=%b out_valid=%b exp 1/0", in_ready, out_valid);
        end
        seen = 1'b0;
        repeat (80) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        checks++;
        if (seen) begin errors++; $display("[TB] FAIL kill_no_result got out_valid pulse exp none"); end
        do_op(2'b00, 64'd3, 64'd5, 0, 1'b0, res, lat, stable, post_ok);
        checks++;
        if (res !== 64'd15 || lat !== LATENCY) begin
            errors++; $display("[TB] FAIL kill_followup got=%h lat=%0d exp=f lat=%0d", res, lat, LATENCY);
        end

        in_valid = 1'b1;
        rs1      = 64'd11;
        rs2      = 64'd2;
        tick();
        in_valid = 1'b0;
        for (int c = 0; c < 200 && out_valid !== 1'b1; c++) tick();
        kill = 1'b1;
        tick();
        kill = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result !== '0) begin
            errors++; $display("[TB] FAIL kill_done got out_valid=%b in_ready=%b result=%h exp 0/1/0", out_valid, in_ready, result);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] res;
        int          lat;
        bit          stable;
        bit          post_ok;
        do_op(2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 10, 1'b1, res, lat, stable, post_ok);
        checks++;
        if (res !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("[TB] FAIL bp_result got=%h exp=ffffffffffffffff", res); end
        checks++;
        if (!stable) begin errors++; $display("[TB] FAIL bp_stable got unstable exp stable out_valid/result, in_ready=0"); end
        checks++;
        if (!post_ok) begin errors++; $display("[TB] FAIL bp_retire got out_valid=%b in_ready=%b exp 0/1", out_valid, in_ready); end
        tick();
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_no_accept got in_ready=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid();
        logic [63:0] res;
        int          lat;
        bit          stable;
        bit          post_ok;
        bit          seen;
        for (int pass = 0; pass < 2; pass++) begin
            in_valid = 1'b1;
            op       = 2'b11;
            rs1      = 64'd100;
            rs2      = 64'd200;
            tick();
            in_valid = 1'b0;
            if (pass == 0) repeat (20) tick();
            else for (int c = 0; c < 200 && out_valid !== 1'b1; c++) tick();
            rst_n = 1'b0;
            tick();
            rst_n = 1'b1;
            checks++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
                errors++; $display("[TB] FAIL reset_mid #%0d got in_ready=%b out_valid=%b result=%h exp 1/0/0", pass, in_ready, out_valid, result);
            end
            seen = 1'b0;
            repeat (80) begin
                tick();
                if (out_valid !== 1'b0) seen = 1'b1;
            end
            checks++;
            if (seen) begin errors++; $display("[TB] FAIL reset_mid_no_result #%0d got out_valid pulse exp none", pass); end
        end
        do_op(2'b00, 64'h1234_5678_9ABC_DEF0, 64'h10, 0, 1'b0, res, lat, stable, post_ok);
        checks++;
        if (res !== 64'h2345_6789_ABCD_EF00) begin errors++; $display("[TB] FAIL reset_recover got=%h exp=23456789abcdef00", res); end
    endtask

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 64'h0;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return 64'h1;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic test_random();
        logic [1:0]  o;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp_res;
        logic [63:0] res;
        int          lat;
        bit          stable;
        bit          post_ok;
        for (int i = 0; i < 300; i++) begin
            o       = 2'($urandom);
            a       = pick_operand();
            b       = pick_operand();
            exp_res = ref_model(o, a, b);
            do_op(o, a, b, $urandom_range(0, 2), 1'b0, res, lat, stable, post_ok);
            checks++;
            if (res !== exp_res) begin
                errors++; $display("[TB] FAIL rand_result #%0d op=%0d a=%h b=%h got=%h exp=%h", i, o, a, b, res, exp_res);
            end
            checks++;
            if (lat !== LATENCY || !stable || !post_ok) begin
                errors++; $display("[TB] FAIL rand_timing #%0d got lat=%0d stable=%b retire=%b exp lat=%0d 1/1", i, lat, stable, post_ok, LATENCY);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_kill();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
